// File: rtl/relu_stream_stage.sv
// relu_stream_stage: AXI4-Stream ReLU stage with optional frame-length based TLAST regeneration,
// a 2-entry skid buffer on the output and a small AXI4 write-only configuration port.
// Build option: define LEAKY_RELU_EN to shift negative beats right by LEAK_SHIFT instead of
// clearing them (enables register 0x08).

module relu_stream_stage #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned AXI_BUS_WIDTH   = 32,
  parameter int unsigned AXI_ADDR_WIDTH  = 10,
  parameter int unsigned FRAME_LEN_WIDTH = 16
) (
  input  logic                        axi_clk,
  input  logic                        axi_reset,
  input  logic                        s_axis_valid,
  output logic                        s_axis_ready,
  input  logic                        s_axis_last,
  input  logic [DATA_WIDTH-1:0]       s_axis_data,
  input  logic [AXI_BUS_WIDTH/8-1:0]  s_axis_keep,
  output logic                        m_axis_valid,
  input  logic                        m_axis_ready,
  output logic                        m_axis_last,
  output logic [DATA_WIDTH-1:0]       m_axis_data,
  output logic [AXI_BUS_WIDTH/8-1:0]  m_axis_keep,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_BUS_WIDTH-1:0]    s_axi_wdata,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready
);

  localparam int unsigned KeepWidth = AXI_BUS_WIDTH / 8;
  localparam logic [FRAME_LEN_WIDTH-1:0] CntOne = FRAME_LEN_WIDTH'(1);
  localparam logic [AXI_ADDR_WIDTH-1:0] AddrCtrl     = AXI_ADDR_WIDTH'(32'h00);
  localparam logic [AXI_ADDR_WIDTH-1:0] AddrFrameLen = AXI_ADDR_WIDTH'(32'h04);
  localparam logic [AXI_ADDR_WIDTH-1:0] AddrLeak     = AXI_ADDR_WIDTH'(32'h08);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} skid_state_e;

  // Configuration: shadow copies take writes, active copies drive the datapath.
  logic [1:0]                 r_ctrl, r_ctrl_sh;
  logic [FRAME_LEN_WIDTH-1:0] r_frame_len, r_frame_len_sh;
  logic [FRAME_LEN_WIDTH-1:0] r_beat_cnt, w_cnt_d;
  logic                       r_bvalid, r_aw_ready;
  logic                       w_wr_en, w_bvalid_d, w_boundary;
  logic                       w_unused_wdata;

  // Stream datapath
  skid_state_e               r_state, w_state_d;
  logic                      r_s_ready;
  logic [DATA_WIDTH-1:0]     r_head_data, r_skid_data;
  logic                      r_head_last, r_skid_last;
  logic [KeepWidth-1:0]      r_head_keep, r_skid_keep;
  logic                      w_in_fire, w_out_fire;
  logic                      w_load_head_in, w_load_head_skid, w_load_skid;
  logic [DATA_WIDTH-1:0]     w_act_data, w_act_neg;
  logic                      w_in_last, w_regen, w_cnt_at_end;

`ifdef LEAKY_RELU_EN
  logic [4:0] r_leak_shift, r_leak_shift_sh;
  assign w_act_neg = $unsigned($signed(s_axis_data) >>> r_leak_shift);
`else
  assign w_act_neg = '0;
`endif

  assign w_unused_wdata = ^s_axi_wdata[AXI_BUS_WIDTH-1:FRAME_LEN_WIDTH];

  assign w_in_fire  = s_axis_valid & r_s_ready;
  assign w_out_fire = (r_state != StEmpty) & m_axis_ready;

  // Activation and TLAST are resolved on the input side so buffered beats are final.
  assign w_act_data   = (r_ctrl[0] && s_axis_data[DATA_WIDTH-1]) ? w_act_neg : s_axis_data;
  assign w_regen      = r_ctrl[1] && (r_frame_len != '0);
  assign w_cnt_at_end = (r_beat_cnt == (r_frame_len - CntOne));
  assign w_in_last    = w_regen ? w_cnt_at_end : s_axis_last;

  // Frame boundary: start of frame with no beat in flight this cycle.
  assign w_boundary = (r_beat_cnt == '0) && !w_in_fire;

  assign w_wr_en    = s_axi_awvalid & s_axi_wvalid & r_aw_ready;
  assign w_bvalid_d = w_wr_en | (r_bvalid & ~s_axi_bready);

  // Beat counter next state; held at zero whenever regeneration is inactive.
  always_comb begin
    w_cnt_d = r_beat_cnt;
    if (!w_regen) begin
      w_cnt_d = '0;
    end else if (w_in_fire) begin
      w_cnt_d = w_cnt_at_end ? '0 : r_beat_cnt + CntOne;
    end
  end

  // Skid buffer next-state and load selects.
  always_comb begin
    w_state_d        = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    unique case (r_state)
      StEmpty: begin
        if (w_in_fire) begin
          w_state_d      = StOne;
          w_load_head_in = 1'b1;
        end
      end
      StOne: begin
        if (w_in_fire && !w_out_fire) begin
          w_state_d   = StFull;
          w_load_skid = 1'b1;
        end else if (!w_in_fire && w_out_fire) begin
          w_state_d = StEmpty;
        end else if (w_in_fire && w_out_fire) begin
          w_load_head_in = 1'b1;
        end
      end
      StFull: begin
        if (w_out_fire) begin
          w_state_d        = StOne;
          w_load_head_skid = 1'b1;
        end
      end
      default: w_state_d = StEmpty;
    endcase
  end

  // Skid buffer storage and registered upstream ready.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_state     <= StEmpty;
      r_s_ready   <= 1'b0;
      r_head_data <= '0;
      r_head_last <= 1'b0;
      r_head_keep <= '0;
      r_skid_data <= '0;
      r_skid_last <= 1'b0;
      r_skid_keep <= '0;
    end else begin
      r_state   <= w_state_d;
      r_s_ready <= (w_state_d != StFull);
      if (w_load_head_in) begin
        r_head_data <= w_act_data;
        r_head_last <= w_in_last;
        r_head_keep <= s_axis_keep;
      end else if (w_load_head_skid) begin
        r_head_data <= r_skid_data;
        r_head_last <= r_skid_last;
        r_head_keep <= r_skid_keep;
      end
      if (w_load_skid) begin
        r_skid_data <= w_act_data;
        r_skid_last <= w_in_last;
        r_skid_keep <= s_axis_keep;
      end
    end
  end

  // Write response handshake; write channels accept only while no response is pending.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_bvalid   <= 1'b0;
      r_aw_ready <= 1'b0;
    end else begin
      r_bvalid   <= w_bvalid_d;
      r_aw_ready <= ~w_bvalid_d;
    end
  end

  // Shadow register writes, boundary copy into active registers, and beat counter.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_ctrl         <= 2'b01;
      r_ctrl_sh      <= 2'b01;
      r_frame_len    <= '0;
      r_frame_len_sh <= '0;
      r_beat_cnt     <= '0;
`ifdef LEAKY_RELU_EN
      r_leak_shift    <= '0;
      r_leak_shift_sh <= '0;
`endif
    end else begin
      r_beat_cnt <= w_cnt_d;
      // Copy uses the pre-write shadow value; a same-cycle write waits for the next boundary.
      if (w_boundary) begin
        r_ctrl      <= r_ctrl_sh;
        r_frame_len <= r_frame_len_sh;
`ifdef LEAKY_RELU_EN
        r_leak_shift <= r_leak_shift_sh;
`endif
      end
      if (w_wr_en) begin
        if (s_axi_awaddr == AddrCtrl) begin
          r_ctrl_sh <= s_axi_wdata[1:0];
        end else if (s_axi_awaddr == AddrFrameLen) begin
          r_frame_len_sh <= s_axi_wdata[FRAME_LEN_WIDTH-1:0];
        end else if (s_axi_awaddr == AddrLeak) begin
`ifdef LEAKY_RELU_EN
          r_leak_shift_sh <= s_axi_wdata[4:0];
`endif
        end
      end
    end
  end

  assign s_axis_ready  = r_s_ready;
  assign m_axis_valid  = (r_state != StEmpty);
  assign m_axis_data   = r_head_data;
  assign m_axis_last   = r_head_last;
  assign m_axis_keep   = r_head_keep;
  assign s_axi_awready = r_aw_ready;
  assign s_axi_wready  = r_aw_ready;
  assign s_axi_bvalid  = r_bvalid;

endmodule

// File: tb/tb_relu_stream_stage.sv
// Testbench for relu_stream_stage: directed scenarios plus randomized traffic, checked against
// a transaction-level model (FIFO of expected beats, occupancy-based ready, config shadowing).

module tb_relu_stream_stage;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  keep;
  } beat_t;

  logic        clk = 1'b0;
  logic        axi_reset;
  logic        s_axis_valid, s_axis_ready, s_axis_last;
  logic [31:0] s_axis_data;
  logic [3:0]  s_axis_keep;
  logic        m_axis_valid, m_axis_ready, m_axis_last;
  logic [31:0] m_axis_data;
  logic [3:0]  m_axis_keep;
  logic [9:0]  s_axi_awaddr;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic        s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready;

  relu_stream_stage dut (
    .axi_clk      (clk),
    .axi_reset    (axi_reset),
    .s_axis_valid (s_axis_valid),
    .s_axis_ready (s_axis_ready),
    .s_axis_last  (s_axis_last),
    .s_axis_data  (s_axis_data),
    .s_axis_keep  (s_axis_keep),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready),
    .m_axis_last  (m_axis_last),
    .m_axis_data  (m_axis_data),
    .m_axis_keep  (m_axis_keep),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Requested drive values, applied to the DUT at the falling edge.
  logic        d_rst = 1'b1, d_sv = 1'b0, d_slast = 1'b0, d_mr = 1'b1;
  logic [31:0] d_sdata = '0, d_wdata = '0;
  logic [3:0]  d_skeep = '0;
  logic [9:0]  d_awaddr = '0;
  logic        d_awv = 1'b0, d_wv = 1'b0, d_br = 1'b1;
  int          stall_cnt = 0;

  // Reference model state
  beat_t       exp_q[$];
  beat_t       out_log[$];
  logic [1:0]  m_ctrl, m_ctrl_sh;
  int          m_fl, m_fl_sh, m_ls, m_ls_sh, m_cnt;
  bit          m_bvalid, m_awready, m_sready, m_after_rst;
  bit          chk_en = 1'b0, last_in_fire, last_wr, saw_not_ready;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: check outputs, apply inputs, advance the model to the coming rising edge.
  task automatic cycle();
    beat_t            b;
    bit               in_fire, out_fire, mvalid, mr_eff;
    logic signed [31:0] sd;
    @(negedge clk);
    mvalid = (exp_q.size() != 0);
    if (chk_en) begin
      check_eq("s_axis_ready", s_axis_ready, m_sready);
      check_eq("m_axis_valid", m_axis_valid, mvalid);
      if (mvalid) begin
        check_eq("m_axis_data", m_axis_data, exp_q[0].data);
        check_eq("m_axis_last", m_axis_last, exp_q[0].last);
        check_eq("m_axis_keep", m_axis_keep, exp_q[0].keep);
      end
      if (m_after_rst) begin
        check_eq("rst_data", {m_axis_data, m_axis_last, m_axis_keep}, 0);
      end
      check_eq("s_axi_bvalid", s_axi_bvalid, m_bvalid);
      check_eq("s_axi_awready", s_axi_awready, m_awready);
      check_eq("s_axi_wready", s_axi_wready, m_awready);
      if (!axi_reset && !s_axis_ready) saw_not_ready = 1'b1;
    end
    mr_eff = (stall_cnt > 0) ? 1'b0 : d_mr;
    if (stall_cnt > 0) stall_cnt--;
    axi_reset = d_rst; s_axis_valid = d_sv; s_axis_data = d_sdata; s_axis_last = d_slast;
    s_axis_keep = d_skeep; m_axis_ready = mr_eff; s_axi_awaddr = d_awaddr;
    s_axi_awvalid = d_awv; s_axi_wdata = d_wdata; s_axi_wvalid = d_wv; s_axi_bready = d_br;
    last_in_fire = 1'b0;
    last_wr = 1'b0;
    if (d_rst) begin
      exp_q.delete();
      m_ctrl = 2'b01; m_ctrl_sh = 2'b01; m_fl = 0; m_fl_sh = 0; m_ls = 0; m_ls_sh = 0;
      m_cnt = 0; m_bvalid = 0; m_awready = 0; m_sready = 0; m_after_rst = 1;
    end else begin
      m_after_rst = 0;
      in_fire  = d_sv && m_sready;
      out_fire = mvalid && mr_eff;
      if (out_fire) begin
        out_log.push_back(exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (in_fire) begin
        sd = d_sdata;
        b.data = d_sdata;
        b.keep = d_skeep;
        if (m_ctrl[0] && sd < 0) begin
`ifdef LEAKY_RELU_EN
          b.data = sd >>> m_ls;
`else
          b.data = 32'h0;
`endif
        end
        if (m_ctrl[1] && m_fl != 0) begin
          b.last = (m_cnt == m_fl - 1);
          m_cnt  = (m_cnt + 1) % m_fl;
        end else begin
          b.last = d_slast;
          m_cnt  = 0;
        end
        exp_q.push_back(b);
      end else if (m_cnt == 0) begin
        m_ctrl = m_ctrl_sh; m_fl = m_fl_sh; m_ls = m_ls_sh;
      end
      if (d_awv && d_wv && m_awready) begin
        last_wr = 1'b1;
        case (d_awaddr)
          10'h000: m_ctrl_sh = d_wdata[1:0];
          10'h004: m_fl_sh   = int'(d_wdata[15:0]);
`ifdef LEAKY_RELU_EN
          10'h008: m_ls_sh   = int'(d_wdata[4:0]);
`endif
          default: ;
        endcase
        m_bvalid = 1;
      end else if (d_br) begin
        m_bvalid = 0;
      end
      m_awready    = !m_bvalid;
      m_sready     = (exp_q.size() != 2);
      last_in_fire = in_fire;
    end
    @(posedge clk);
  endtask

  task automatic send(input logic [31:0] data, input logic last, output int tries);
    tries = 0;
    d_sdata = data; d_slast = last; d_skeep = 4'($urandom);
    d_sv = 1'b1;
    do begin
      cycle();
      tries++;
    end while (!last_in_fire && tries < 50);
    check_eq("send_accept", last_in_fire, 1);
    d_sv = 1'b0;
  endtask

  task automatic idle(input int n);
    d_sv = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    int guard = 0;
    d_sv = 1'b0; d_mr = 1'b1;
    while (exp_q.size() != 0 && guard < 20) begin
      cycle();
      guard++;
    end
    cycle();
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  task automatic cfg_write(input logic [9:0] addr, input logic [31:0] data, input int hold);
    int guard = 0;
    d_awaddr = addr; d_wdata = data; d_awv = 1'b1; d_wv = 1'b1; d_br = 1'b0;
    do begin
      cycle();
      guard++;
    end while (!last_wr && guard < 20);
    check_eq("cfg_accept", last_wr, 1);
    d_awv = 1'b0; d_wv = 1'b0;
    for (int i = 0; i < hold; i++) cycle();
    d_br = 1'b1;
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          tries;
    logic [31:0] vin [4];
    logic [31:0] vexp[4];
    logic [31:0] burst[8];
    logic [31:0] leak_exp;

    // Reset
    cycle();
    chk_en = 1'b1;
    cycle();
    d_rst = 1'b0;
    cycle();
    cycle();

    // Basic activation, one beat per cycle
    vin[0] = 32'h0000_0005; vin[1] = 32'hFFFF_FFFB; vin[2] = 32'h8000_0000; vin[3] = 32'h7FFF_FFFF;
    vexp[0] = 32'h5; vexp[1] = 32'h0; vexp[2] = 32'h0; vexp[3] = 32'h7FFF_FFFF;
    out_log.delete();
    for (int i = 0; i < 4; i++) begin
      send(vin[i], 1'b0, tries);
      check_eq("one_per_cycle", tries, 1);
    end
    drain();
    check_eq("basic_count", out_log.size(), 4);
    for (int i = 0; i < 4 && i < out_log.size(); i++) check_eq("basic_data", out_log[i].data, vexp[i]);

    // Backpressure mid-burst
    out_log.delete();
    saw_not_ready = 1'b0;
    for (int i = 0; i < 8; i++) burst[i] = 32'(i * 17 + 3);
    for (int i = 0; i < 8; i++) begin
      send(burst[i], 1'b0, tries);
      if (i == 1) stall_cnt = 3;
    end
    drain();
    check_eq("bp_ready_dropped", saw_not_ready, 1);
    check_eq("bp_count", out_log.size(), 8);
    for (int i = 0; i < 8 && i < out_log.size(); i++) check_eq("bp_order", out_log[i].data, burst[i]);

    // TLAST regeneration, N=4, with a delayed bready
    cfg_write(10'h004, 32'd4, 3);
    cfg_write(10'h000, 32'h3, 0);
    idle(2);
    out_log.delete();
    for (int i = 0; i < 8; i++) send(32'($urandom_range(0, 1000)), 1'b0, tries);
    drain();
    check_eq("regen_count", out_log.size(), 8);
    for (int i = 0; i < 8 && i < out_log.size(); i++)
      check_eq("regen_last", out_log[i].last, (i == 3 || i == 7));

    // Frame length change mid-frame takes effect only at the next boundary
    out_log.delete();
    send(32'd1, 1'b0, tries);
    send(32'd2, 1'b0, tries);
    cfg_write(10'h004, 32'd6, 0);
    send(32'd3, 1'b0, tries);
    send(32'd4, 1'b0, tries);
    idle(1);
    for (int i = 0; i < 6; i++) send(32'(10 + i), 1'b0, tries);
    drain();
    check_eq("midframe_count", out_log.size(), 10);
    for (int i = 0; i < 10 && i < out_log.size(); i++)
      check_eq("midframe_last", out_log[i].last, (i == 3 || i == 9));

    // Reset with two beats buffered
    d_mr = 1'b0;
    send(32'd77, 1'b0, tries);
    send(32'd78, 1'b0, tries);
    d_rst = 1'b1;
    cycle();
    d_rst = 1'b0;
    d_mr = 1'b1;
    cycle();
    out_log.delete();
    send(32'hFFFF_FFF0, 1'b1, tries);
    send(32'd7, 1'b0, tries);
    drain();
    check_eq("post_rst_count", out_log.size(), 2);
    if (out_log.size() == 2) begin
      check_eq("post_rst_relu", out_log[0].data, 0);
      check_eq("post_rst_last0", out_log[0].last, 1);
      check_eq("post_rst_last1", out_log[1].last, 0);
    end

    // Leak shift register
    cfg_write(10'h008, 32'd2, 1);
    idle(2);
    out_log.delete();
    send(32'hFFFF_FFF0, 1'b0, tries);
    drain();
`ifdef LEAKY_RELU_EN
    leak_exp = 32'hFFFF_FFFC;
`else
    leak_exp = 32'h0;
`endif
    check_eq("leak_count", out_log.size(), 1);
    if (out_log.size() == 1) check_eq("leak_data", out_log[0].data, leak_exp);

    // Randomized traffic with concurrent config writes
    for (int c = 0; c < 1500; c++) begin
      d_sv    = ($urandom % 4) != 0;
      d_sdata = $urandom;
      d_slast = 1'($urandom);
      d_skeep = 4'($urandom);
      d_mr    = ($urandom % 3) != 0;
      d_br    = 1'($urandom);
      d_awv   = ($urandom % 5) == 0;
      d_wv    = ($urandom % 5) == 0;
      case ($urandom % 5)
        0: begin d_awaddr = 10'h000; d_wdata = 32'($urandom % 4); end
        1: begin d_awaddr = 10'h004; d_wdata = 32'($urandom % 7); end
        2: begin d_awaddr = 10'h008; d_wdata = 32'($urandom % 32); end
        3: begin d_awaddr = 10'h00C; d_wdata = $urandom; end
        default: begin d_awaddr = 10'h3FC; d_wdata = $urandom; end
      endcase
      cycle();
    end
    d_awv = 1'b0; d_wv = 1'b0; d_br = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
